// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive buffer
//
// Purpose: data width, ingress FSM state type and default FIFO depth used by
// uart_rx_fifo and its testbench.
package uart_pkg;

  localparam int UART_DATA_W         = 8;
  localparam int UART_DEPTH_LOG2_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - storage array with one write port and asynchronous read
//
// Purpose: holds FIFO entries only; pointers and flags live in the parent.
// Contents are not reset.
// Ports:
//   i_clk    clock for the write port
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  combinational read data at i_raddr
module sync_fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive buffer: ingress handshake plus FWFT circular FIFO
//
// Purpose: captures each byte flagged by the UART receiver, acknowledges it
// with a one-cycle rx_done pulse, and queues it for the CPU register block.
// Optional feature macro: UART_RX_FIFO_HWM_IRQ_EN (adds HWM_LEVEL and o_irq).
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_rx_rdy         receiver byte-ready level (held until acknowledged)
//   i_rx_data        receiver byte, valid while i_rx_rdy=1
//   o_rx_done        one-cycle acknowledge to the receiver
//   i_rd_en          CPU pop strobe
//   o_rd_data        head entry (first-word-fall-through)
//   o_rd_valid       FIFO not empty
//   o_level          entry count 0..2^DEPTH_LOG2
//   o_overrun        sticky: a byte was dropped while full
//   i_ovr_clr        clears o_overrun (a drop in the same cycle wins)
//   o_irq            high-water / overrun interrupt (feature builds only)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_DEPTH_LOG2_DEF
`ifdef UART_RX_FIFO_HWM_IRQ_EN
  , parameter int HWM_LEVEL = 12
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx_rdy,
  input  logic [UART_DATA_W-1:0] i_rx_data,
  output logic                   o_rx_done,
  input  logic                   i_rd_en,
  output logic [UART_DATA_W-1:0] o_rd_data,
  output logic                   o_rd_valid,
  output logic [DEPTH_LOG2:0]    o_level,
  output logic                   o_overrun,
  input  logic                   i_ovr_clr
`ifdef UART_RX_FIFO_HWM_IRQ_EN
  , output logic                 o_irq
`endif
);

  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  rx_state_t               r_state;
  rx_state_t               w_state_next;
  logic                    r_rx_done;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_level;
  logic [DEPTH_LOG2:0]     w_level_next;
  logic                    r_overrun;
  logic                    w_overrun_next;
  logic                    w_capture;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_push;
  logic                    w_drop;

  // A pop in the same edge frees a slot, so a full FIFO can still accept.
  assign w_capture = (r_state == ST_IDLE) && i_rx_rdy;
  assign w_pop     = i_rd_en && (r_level != '0);
  assign w_full    = (r_level == LVL_FULL) && !w_pop;
  assign w_push    = w_capture && !w_full;
  assign w_drop    = w_capture && w_full;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_rx_rdy) w_state_next = ST_ACK;
      ST_ACK:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LVL_ONE;
      2'b01:   w_level_next = r_level - LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  // Drop sets, clear resets; set has priority.
  assign w_overrun_next = w_drop | (r_overrun & ~i_ovr_clr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_rx_done <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rx_done <= (w_state_next == ST_ACK);
      r_level   <= w_level_next;
      r_overrun <= w_overrun_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  sync_fifo_ram #(
    .WIDTH  (UART_DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_rx_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_rd_data)
  );

  assign o_rx_done  = r_rx_done;
  assign o_rd_valid = (r_level != '0);
  assign o_level    = r_level;
  assign o_overrun  = r_overrun;

`ifdef UART_RX_FIFO_HWM_IRQ_EN
  localparam logic [DEPTH_LOG2:0] LVL_HWM = (DEPTH_LOG2+1)'(HWM_LEVEL);

  logic r_irq;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_level_next >= LVL_HWM) | w_overrun_next;
    end
  end

  assign o_irq = r_irq;
`endif

endmodule
